// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: FSM encoding, default PC step/reset
// vector, and the queue-count width helper.
package fetch_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;

  localparam int unsigned PC_INC_DEF   = 2;
  localparam int unsigned RESET_PC_DEF = 0;

  // Count needs one extra bit so a full queue is distinguishable from empty.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with a registered head word and valid flag;
// flush wins over any same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       valid,
  output logic [W-1:0]               head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = count + CW'(push) - CW'(pop);
  end

  // Head is kept in its own register so decode sees a flop, not a RAM mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_nxt;
      valid <= (cnt_nxt != '0);
      if (pop) begin
        if (count == CW'(1)) begin
          if (push) head <= din;
        end else begin
          head <= mem[rd_ptr + PW'(1)];
        end
      end else if (push && (count == '0)) begin
        head <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_q.sv
// Fetch stage: PC sequencer with one outstanding I-cache read feeding a
// prefetch queue toward decode; redirects flush the queue and squash reads.
module fetch_prefetch_q
  import fetch_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned IW       = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_INC   = PC_INC_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          imem_done,
  input  logic          imem_err,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] inst_pc_next,
  output logic          err
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned W  = IW + AW;

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_n;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   pc_n;
  logic [AW-1:0]   req_addr;
  logic [AW-1:0]   req_addr_n;
  logic [AW-1:0]   addr_inc;
  logic            push;
  logic            pop;
  logic            can_issue;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [W-1:0]    head;

  // Issue is gated on the post-update count, so the slot for the read in
  // flight is always reserved and the queue cannot overflow.
  always_comb begin
    addr_inc  = req_addr + AW'(PC_INC);
    push      = (state == ST_REQ) && imem_done && !redirect;
    pop       = inst_valid && inst_ready;
    cnt_next  = cnt + CW'(push) - CW'(pop);
    can_issue = !halt && !redirect && (cnt_next < CW'(DEPTH));
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          pc_n = redirect_pc;
        end else if (can_issue) begin
          req_addr_n = pc;
          state_n    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_done) begin
          if (redirect) begin
            pc_n    = redirect_pc;
            state_n = ST_IDLE;
          end else begin
            pc_n = addr_inc;
            if (can_issue) req_addr_n = addr_inc;
            else           state_n    = ST_IDLE;
          end
        end else if (redirect) begin
          // The cache cannot abort: hold the address and discard the data.
          pc_n    = redirect_pc;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (redirect)  pc_n    = redirect_pc;
        if (imem_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= AW'(RESET_PC);
      req_addr <= '0;
      imem_rd  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      imem_rd  <= (state_n != ST_IDLE);
      err      <= err | imem_err;
    end
  end

  assign imem_addr = req_addr;

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_data, addr_inc}),
    .count (cnt),
    .valid (inst_valid),
    .head  (head)
  );

  assign inst         = head[W-1:AW];
  assign inst_pc_next = head[AW-1:0];

endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Bench for fetch_prefetch_q: directed scenarios plus a randomized stream
// checked against a queue-based model of the program-order fetch stream.
module tb_fetch_prefetch_q;

  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          halt = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_rd;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          imem_done;
  logic          imem_err = 1'b0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc_next;
  logic          err;

  logic          w_rst_n = 1'b0;
  logic          w_rd;
  logic [AW-1:0] w_addr;
  logic [IW-1:0] w_data;
  logic          w_done;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [IW-1:0] w_inst;
  logic [AW-1:0] w_pc_next;
  logic          w_err;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  logic [15:0] wait_cnt;
  logic [15:0] salt;

  always #5 clk = ~clk;

  function automatic logic [15:0] data_of(input logic [15:0] a, input logic [15:0] s);
    return {a[7:0], a[15:8]} ^ s ^ 16'h3C5A;
  endfunction

  // I-cache stand-in: done after 'lat' wait cycles (0 = hit in the same cycle).
  assign imem_done = imem_rd && (int'(wait_cnt) >= lat);
  assign imem_data = data_of(imem_addr, salt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= '0;
    else if (imem_rd && !imem_done)  wait_cnt <= wait_cnt + 16'd1;
    else                             wait_cnt <= '0;
  end

  assign w_done = w_rd;
  assign w_data = data_of(w_addr, salt);

  fetch_prefetch_q #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .PC_INC(2), .RESET_PC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data), .imem_done(imem_done),
    .imem_err(imem_err), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc_next(inst_pc_next), .err(err)
  );

  fetch_prefetch_q #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .PC_INC(2), .RESET_PC(32'hFFFE)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .halt(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .imem_rd(w_rd), .imem_addr(w_addr), .imem_data(w_data), .imem_done(w_done),
    .imem_err(1'b0), .inst_valid(w_valid), .inst_ready(w_ready), .inst(w_inst),
    .inst_pc_next(w_pc_next), .err(w_err)
  );

  // Park the main DUT: stop fetching, drain the queue, wait for no read.
  task automatic settle_idle();
    bit ok = 1'b0;
    halt = 1'b1; inst_ready = 1'b1; redirect = 1'b0; lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!inst_valid && !imem_rd) begin ok = 1'b1; break; end
    end
    inst_ready = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL settle_idle: inst_valid=%b imem_rd=%b required 0 0", inst_valid, imem_rd);
    end
  endtask

  task automatic wait_rd(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (imem_rd) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_rd: imem_rd=0 after 30 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({imem_rd, inst_valid, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: rd/valid/err=%b required 000", {imem_rd, inst_valid, err});
    end
    checks++;
    if (imem_addr !== 16'h0000) begin
      failures++; $display("FAIL reset_addr: got %h required 0000", imem_addr);
    end
    checks++;
    if (inst !== 16'h0000 || inst_pc_next !== 16'h0000) begin
      failures++; $display("FAIL reset_head: inst=%h pc_next=%h required 0000 0000", inst, inst_pc_next);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic        rd_s [6];
    logic [15:0] ad_s [6];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_s[i] = imem_rd; ad_s[i] = imem_addr;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_s[i] !== 1'b1 || ad_s[i] !== 16'(2 * i)) begin
        failures++;
        $display("FAIL fill_read%0d: rd=%b addr=%h required 1 %h", i, rd_s[i], ad_s[i], 16'(2 * i));
      end
    end
    for (int i = 4; i < 6; i++) begin
      checks++;
      if (rd_s[i] !== 1'b0) begin
        failures++; $display("FAIL fill_stop%0d: rd=%b required 0", i, rd_s[i]);
      end
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc_next !== 16'h0002 || inst !== data_of(16'h0000, salt)) begin
      failures++;
      $display("FAIL fill_head: valid=%b pc_next=%h inst=%h required 1 0002 %h",
               inst_valid, inst_pc_next, inst, data_of(16'h0000, salt));
    end
    checks++;
    if (u_dut.cnt !== 3'd4) begin
      failures++; $display("FAIL fill_count: got %0d required 4", u_dut.cnt);
    end
  endtask

  task automatic test_pop_refill();
    int extra = 0;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0008) begin
      failures++; $display("FAIL refill_read: rd=%b addr=%h required 1 0008", imem_rd, imem_addr);
    end
    checks++;
    if (inst_pc_next !== 16'h0004 || inst !== data_of(16'h0002, salt)) begin
      failures++; $display("FAIL refill_head: pc_next=%h inst=%h required 0004 %h",
                           inst_pc_next, inst, data_of(16'h0002, salt));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (imem_rd) extra++;
      checks++;
      if (u_dut.cnt !== 3'd4) begin
        failures++; $display("FAIL refill_count%0d: got %0d required 4", i, u_dut.cnt);
      end
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL refill_extra_reads: got %0d required 0", extra);
    end
  endtask

  task automatic test_miss_redirect();
    int  held = 0;
    bit  found;
    halt = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc_next !== 16'(4 + 2 * k) || inst !== data_of(16'(2 + 2 * k), salt)) begin
        failures++;
        $display("FAIL drain_order%0d: valid=%b pc_next=%h inst=%h required 1 %h %h", k,
                 inst_valid, inst_pc_next, inst, 16'(4 + 2 * k), data_of(16'(2 + 2 * k), salt));
      end
      @(negedge clk);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty: valid=%b required 0", inst_valid);
    end
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0; lat = 9; halt = 1'b0;
    wait_rd(found);
    while (imem_rd && held < 30) begin
      checks++;
      if (imem_addr !== 16'h0010 || inst_valid !== 1'b0) begin
        failures++; $display("FAIL miss_hold%0d: addr=%h valid=%b required 0010 0", held, imem_addr, inst_valid);
      end
      redirect = (held == 2); redirect_pc = 16'h0100;
      held++;
      @(negedge clk);
    end
    redirect = 1'b0; lat = 0;
    checks++;
    if (held != 10) begin
      failures++; $display("FAIL miss_cycles: got %0d required 10", held);
    end
    wait_rd(found);
    halt = 1'b1;
    checks++;
    if (imem_addr !== 16'h0100 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL miss_next_read: addr=%h valid=%b required 0100 0", imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_flush();
    bit found = 1'b0;
    settle_idle();
    redirect = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    redirect = 1'b0; halt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_rd && imem_addr == 16'h0204) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || u_dut.cnt !== 3'd2 || inst_valid !== 1'b1) begin
      failures++; $display("FAIL flush_setup: found=%b count=%0d valid=%b required 1 2 1", found, u_dut.cnt, inst_valid);
    end
    redirect = 1'b1; redirect_pc = 16'h0300; inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || u_dut.cnt !== 3'd0 || imem_rd !== 1'b0) begin
      failures++; $display("FAIL flush_empty: valid=%b count=%0d rd=%b required 0 0 0", inst_valid, u_dut.cnt, imem_rd);
    end
    wait_rd(found);
    checks++;
    if (imem_addr !== 16'h0300) begin
      failures++; $display("FAIL flush_next_read: addr=%h required 0300", imem_addr);
    end
    @(negedge clk);
    halt = 1'b1;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc_next !== 16'h0302 || inst !== data_of(16'h0300, salt)) begin
      failures++; $display("FAIL flush_new_head: valid=%b pc_next=%h required 1 0302", inst_valid, inst_pc_next);
    end
  endtask

  task automatic test_halt_miss();
    int  done_n = 0;
    int  stray = 0;
    bit  found;
    settle_idle();
    redirect = 1'b1; redirect_pc = 16'h0400;
    @(negedge clk);
    redirect = 1'b0; lat = 5; halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0400) begin
      failures++; $display("FAIL halt_issue: rd=%b addr=%h required 1 0400", imem_rd, imem_addr);
    end
    for (int i = 0; i < 15; i++) begin
      if (imem_rd && imem_done) done_n++;
      if (imem_rd && imem_addr != 16'h0400) stray++;
      @(negedge clk);
    end
    checks++;
    if (done_n != 1 || stray != 0 || imem_rd !== 1'b0) begin
      failures++; $display("FAIL halt_reads: done=%0d stray=%0d rd=%b required 1 0 0", done_n, stray, imem_rd);
    end
    checks++;
    if (inst_valid !== 1'b1 || u_dut.cnt !== 3'd1 || inst_pc_next !== 16'h0402) begin
      failures++; $display("FAIL halt_enqueue: valid=%b count=%0d pc_next=%h required 1 1 0402",
                           inst_valid, u_dut.cnt, inst_pc_next);
    end
    lat = 0; halt = 1'b0;
    wait_rd(found);
    halt = 1'b1;
    checks++;
    if (imem_addr !== 16'h0402) begin
      failures++; $display("FAIL halt_resume: addr=%h required 0402", imem_addr);
    end
  endtask

  task automatic test_pc_wrap();
    logic        rd_s [6];
    logic [15:0] ad_s [6];
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'h0000, 16'h0002, 16'h0004};
    checks++;
    if (w_rd !== 1'b0 || w_valid !== 1'b0 || w_err !== 1'b0) begin
      failures++; $display("FAIL wrap_reset: rd=%b valid=%b err=%b required 0 0 0", w_rd, w_valid, w_err);
    end
    @(negedge clk);
    w_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd_s[i] = w_rd; ad_s[i] = w_addr;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_s[i] !== 1'b1 || ad_s[i] !== exp_a[i]) begin
        failures++; $display("FAIL wrap_read%0d: rd=%b addr=%h required 1 %h", i, rd_s[i], ad_s[i], exp_a[i]);
      end
    end
    checks++;
    if (w_valid !== 1'b1 || w_pc_next !== 16'h0000 || w_inst !== data_of(16'hFFFE, salt)) begin
      failures++; $display("FAIL wrap_head: valid=%b pc_next=%h required 1 0000", w_valid, w_pc_next);
    end
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    checks++;
    if (w_pc_next !== 16'h0002 || w_inst !== data_of(16'h0000, salt)) begin
      failures++; $display("FAIL wrap_second: pc_next=%h required 0002", w_pc_next);
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] q [$];
    logic [15:0] fp, cur, start;
    bit active, squashed, ph, pr;
    settle_idle();
    start = 16'($urandom) & 16'hFFFE;
    halt = 1'b1; redirect = 1'b1; redirect_pc = start; inst_ready = 1'b0;
    fp = start; cur = start; active = 1'b0; squashed = 1'b0; ph = 1'b1; pr = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== (q.size() != 0)) begin
        failures++; $display("FAIL rnd_valid@%0d: got %b required %b", cyc, inst_valid, q.size() != 0);
      end
      if (inst_valid && q.size() != 0) begin
        checks++;
        if (inst !== data_of(q[0], salt) || inst_pc_next !== q[0] + 16'd2) begin
          failures++; $display("FAIL rnd_head@%0d: inst=%h pc_next=%h required %h %h",
                               cyc, inst, inst_pc_next, data_of(q[0], salt), q[0] + 16'd2);
        end
      end
      if (imem_rd && !active) begin
        checks++;
        if (imem_addr !== fp || ph || pr || q.size() > DEPTH - 1) begin
          failures++; $display("FAIL rnd_issue@%0d: addr=%h halt=%b redir=%b qsize=%0d required %h 0 0 <=%0d",
                               cyc, imem_addr, ph, pr, q.size(), fp, DEPTH - 1);
        end
        cur = imem_addr;
      end else if (imem_rd) begin
        checks++;
        if (imem_addr !== cur) begin
          failures++; $display("FAIL rnd_addr_hold@%0d: got %h required %h", cyc, imem_addr, cur);
        end
      end else if (active) begin
        checks++; failures++;
        $display("FAIL rnd_read_dropped@%0d: rd=%b required 1", cyc, imem_rd);
      end
      halt        = ($urandom_range(0, 9) < 3);
      inst_ready  = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      lat         = $urandom_range(0, 3);
      #1;
      if (inst_valid && inst_ready && q.size() != 0) void'(q.pop_front());
      if (imem_rd && imem_done) begin
        if (!squashed && !redirect) begin q.push_back(cur); fp = cur + 16'd2; end
        active = 1'b0; squashed = 1'b0;
      end else if (imem_rd) begin
        active = 1'b1;
        if (redirect) squashed = 1'b1;
      end
      if (redirect) begin fp = redirect_pc; q.delete(); end
      ph = halt; pr = redirect;
    end
    halt = 1'b1; redirect = 1'b0; inst_ready = 1'b0; lat = 0;
  endtask

  task automatic test_err();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b required 0", err); end
    imem_err = 1'b1;
    @(negedge clk);
    imem_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (err !== 1'b1) begin failures++; $display("FAIL err_sticky%0d: got %b required 1", i, err); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    settle_idle();
    lat = 9; halt = 1'b0;
    wait_rd(found);
    halt = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_rd, inst_valid, err} !== 3'b000 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL async_reset_ctrl: rd/valid/err=%b addr=%h required 000 0000",
                           {imem_rd, inst_valid, err}, imem_addr);
    end
    checks++;
    if (inst !== 16'h0000 || inst_pc_next !== 16'h0000) begin
      failures++; $display("FAIL async_reset_head: inst=%h pc_next=%h required 0000 0000", inst, inst_pc_next);
    end
    @(negedge clk);
    rst_n = 1'b1; lat = 0;
    @(negedge clk);
    checks++;
    if (imem_rd !== 1'b0) begin failures++; $display("FAIL async_reset_idle: rd=%b required 0", imem_rd); end
  endtask

  initial begin
    salt = 16'($urandom);
    test_reset();
    test_fill();
    test_pop_refill();
    test_miss_redirect();
    test_redirect_flush();
    test_halt_miss();
    test_pc_wrap();
    test_random_stream();
    test_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
